// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings for the sequential ALU.
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL1 = 4'd5,
        OP_SHR1 = 4'd6,
        OP_CMP  = 4'd7,
        OP_SHLN = 4'd8,
        OP_SHRN = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle ALU operations (opcodes 0-7); any other opcode yields zero result and carry.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        case (op_i)
            // Borrow falls out of the extended subtraction's top bit.
            OP_ADD:  {carry_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  {carry_o, res_o} = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SHL1: begin
                res_o   = a_i << 1;
                carry_o = a_i[WIDTH-1];
            end
            OP_SHR1: begin
                res_o   = a_i >> 1;
                carry_o = a_i[0];
            end
            OP_CMP:  res_o[0] = (a_i == b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered flags and bit-serial variable shifts.
// Define ALU_SEQ_MUL_EN to add a shift-add multiplier on opcode 10.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam logic [WIDTH-1:0]   WIDTH_V = WIDTH'(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_MAX = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_e             state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;

    alu_op_e            op_in;
    logic               is_shn;
    logic [WIDTH-1:0]   core_res;
    logic               core_carry;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_carry;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     psum;
`endif

    assign op_in      = alu_op_e'(alu_op);
    assign is_shn     = (op_in == OP_SHLN) || (op_in == OP_SHRN);
    assign single_res = is_shn ? r0 : core_res;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (r0),
        .b_i     (r1),
        .op_i    (op_in),
        .res_o   (core_res),
        .carry_o (core_carry)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        fin_res   = '0;
        fin_carry = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d    = prod_q;
        psum      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op_in;
                    if (is_shn && (r1 != '0)) begin
                        acc_d   = r0;
                        cnt_d   = (r1 >= WIDTH_V) ? CNT_MAX : SHAMT_W'(r1);
                        state_d = RUN;
`ifdef ALU_SEQ_MUL_EN
                    end else if (op_in == OP_MUL) begin
                        acc_d               = r0;
                        prod_d              = '0;
                        prod_d[WIDTH-1:0]   = r1;
                        cnt_d               = CNT_MAX;
                        state_d             = RUN;
`endif
                    end else begin
                        // Zero-count shifts pass r0 through; core reports no carry for them.
                        result_d = single_res;
                        carry_d  = core_carry;
                        zero_d   = (single_res == '0);
                        state_d  = HOLD;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                case (op_q)
                    OP_SHLN: begin
                        acc_d     = acc_q << 1;
                        fin_res   = acc_q << 1;
                        fin_carry = acc_q[WIDTH-1];
                    end
                    OP_SHRN: begin
                        acc_d     = acc_q >> 1;
                        fin_res   = acc_q >> 1;
                        fin_carry = acc_q[0];
                    end
`ifdef ALU_SEQ_MUL_EN
                    // Right-shifting product: upper half accumulates, multiplier drains from the low half.
                    OP_MUL: begin
                        psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
                        prod_d    = {psum, prod_q[WIDTH-1:1]};
                        fin_res   = prod_d[WIDTH-1:0];
                        fin_carry = |prod_d[2*WIDTH-1:WIDTH];
                    end
`endif
                    default: state_d = IDLE;
                endcase
                if (cnt_q == CNT_ONE) begin
                    state_d  = HOLD;
                    result_d = fin_res;
                    carry_d  = fin_carry;
                    zero_d   = (fin_res == '0);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: randomized ops against a behavioural model, plus reset/backpressure cases.
module tb_alu_seq;

    localparam int W = 8;
    localparam longint unsigned MOD = 64'd1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .r0        (r0),
        .r1        (r1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned res;
        longint unsigned zero;
        longint unsigned carry;
        longint unsigned lat;
        int              acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rdy_mode = 0;
    bit   mon_first = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model straight from the opcode rules, using wide integer arithmetic.
    function automatic exp_t model(input longint unsigned op, input longint unsigned a, input longint unsigned b);
        exp_t e;
        longint unsigned n;
        longint unsigned full;
        e.res = 0; e.carry = 0; e.lat = 1; e.acc = 0;
        n = 0; full = 0;
        case (op)
            0: begin full = a + b; e.res = full % MOD; e.carry = full / MOD; end
            1: begin e.res = (a + MOD - b) % MOD; e.carry = (a < b) ? 1 : 0; end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: begin e.res = (a * 2) % MOD; e.carry = a / (MOD / 2); end
            6: begin e.res = a / 2; e.carry = a % 2; end
            7: e.res = (a == b) ? 1 : 0;
            8, 9: begin
                n = (b < W) ? b : W;
                if (n == 0) begin
                    e.res = a;
                end else begin
                    e.lat = n + 1;
                    if (op == 8) begin
                        e.res   = (a << n) % MOD;
                        e.carry = (a >> (W - n)) % 2;
                    end else begin
                        e.res   = a >> n;
                        e.carry = (a >> (n - 1)) % 2;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            10: begin full = a * b; e.res = full % MOD; e.carry = (full >= MOD) ? 1 : 0; e.lat = W + 1; end
`endif
            default: ;
        endcase
        e.zero = (e.res == 0) ? 1 : 0;
        return e;
    endfunction

    // Entered and left at posedge+1; pushes the expectation in the cycle the request is accepted.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   waited;
        e = model(64'(op), 64'(a), 64'(b));
        waited = 0;
        in_valid = 1'b1; alu_op = op; r0 = a; r1 = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            e.acc = cyc;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            alu_op = 4'($urandom); r0 = W'($urandom); r1 = W'($urandom);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (!(sb.size() == 0 && in_ready) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    // Consumer readiness; updated after the driver so mode changes take effect the same cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every presented result against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_first = 1'b1;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(1), 64'(0));
                end else begin
                    if (mon_first) begin
                        chk("latency", 64'(cyc - sb[0].acc), sb[0].lat);
                        chk("in_ready_while_valid", 64'(in_ready), 64'(0));
                        mon_first = 1'b0;
                    end
                    chk("data{res,zero,carry}", 64'({result, zero, carry}),
                        (sb[0].res << 2) | (sb[0].zero << 1) | sb[0].carry);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        mon_first = 1'b1;
                    end
                end
            end
        end
    end

    localparam logic [19:0] DIR [12] = '{
        {4'd0,  8'hF0, 8'h20}, {4'd1,  8'h05, 8'h05}, {4'd1,  8'h03, 8'h04},
        {4'd8,  8'h81, 8'h03}, {4'd8,  8'h81, 8'h09}, {4'd9,  8'h5A, 8'h00},
        {4'd7,  8'h3C, 8'h3C}, {4'd10, 8'h10, 8'h20}, {4'd7,  8'h3C, 8'h3D},
        {4'd5,  8'h80, 8'h00}, {4'd9,  8'h81, 8'h08}, {4'd13, 8'hFF, 8'hFF}
    };

    initial begin
        logic [19:0]  w;
        logic [3:0]   op;
        logic [W-1:0] b;
        int           seen;

        reset = 1'b1; in_valid = 1'b0; alu_op = '0; r0 = '0; r1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_result",    64'(result),    64'(0));
        chk("rst_zero",      64'(zero),      64'(0));
        chk("rst_carry",     64'(carry),     64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            w = DIR[i];
            issue(w[19:16], w[15:8], w[7:0]);
        end
        wait_idle();

        // Backpressure: result must stay put and no second request may be taken.
        rdy_mode = 1;
        issue(4'd0, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; r0 = W'($urandom); alu_op = 4'($urandom_range(0, 7));
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'(1));
        chk("bp_release_out_valid", 64'(out_valid), 64'(0));
        rdy_mode = 0;
        wait_idle();

        // Reset during a multi-cycle shift aborts it with no result.
        issue(4'd9, 8'hA5, 8'd6);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_rst_out_valid", 64'(out_valid), 64'(0));
        chk("abort_rst_result",    64'(result),    64'(0));
        chk("abort_rst_flags",     64'({zero, carry}), 64'(0));
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_out_valid", 64'(seen), 64'(0));
        @(posedge clk); #1;
        issue(4'd7, 8'h3C, 8'h3C);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 || op == 4'd9)
                b = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, W + 1));
            else
                b = W'($urandom);
            issue(op, W'($urandom), b);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
